sseg_scan_driver: RTL and testbench
===================================

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digits scanned, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clocks per digit slot, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: 1 runs the scan, 0 freezes it and blanks the display.
REQ-006 SHALL have port load, input, 1 bit: capture all digit inputs into the shadow register.
REQ-007 SHALL have port hex_in, input, 4*NUM_DIGITS bits: digit k is hex_in[4k+3:4k], and digit 0 is rightmost.
REQ-008 SHALL have port dp_in, input, NUM_DIGITS bits: 1 lights the decimal point of digit k.
REQ-009 SHALL have port blank_in, input, NUM_DIGITS bits: 1 forces digit k dark.
REQ-010 SHALL have port cathode_out, output, 8 bits: registered, active-low segments, bit order {dp,g,f,e,d,c,b,a}.
REQ-011 SHALL have port anode_out, output, NUM_DIGITS bits: registered, active-low, one-hot-low digit enables.
REQ-012 SHALL have port digit_idx, output, clog2(NUM_DIGITS) bits with a minimum of 1: the digit currently selected.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last digit slot completes.

Function
REQ-014 SHALL capture hex_in, dp_in and blank_in into the shadow register on the edge where load=1; the scan path SHALL read only the shadow register.
REQ-015 SHALL run refresh counter cnt 0..REFRESH_DIV-1 while enable=1; when cnt=REFRESH_DIV-1, cnt SHALL wrap to 0 and digit_idx SHALL advance.
REQ-016 SHALL wrap digit_idx from NUM_DIGITS-1 to 0 and assert frame_done for exactly the cycle after that wrap edge.
REQ-017 SHALL register outputs from (cnt, digit_idx, shadow) with 1-cycle latency: load at edge n reaches the pins no earlier than edge n+2.
REQ-018 SHALL drive all anode_out bits high and cathode_out=8'hFF whenever the registered cnt is 0; this is the 1-cycle dead time per digit slot.
REQ-019 SHALL, outside dead time, drive anode bit digit_idx low and all other anode bits high.
REQ-020 SHALL, outside dead time, drive cathode_out = ~{dp, glyph(hex)} for the selected digit using the standard hex glyphs (0=3F ... F=71 active-high); a digit with its blank bit set SHALL give cathode_out 8'hFF.
REQ-021 SHALL, while enable=0, hold cnt and digit_idx, force all anodes high, force cathode_out to 8'hFF and keep frame_done at 0; load SHALL still capture.
REQ-022 SHALL give load priority as follows when load coincides with a digit advance: the advance uses the old shadow value and the newly captured value is visible from the next slot.

Reset
REQ-023 SHALL, while reset_n=0, immediately set cnt=0, digit_idx=0, shadow=all zero with all blank bits=1, anode_out all 1, cathode_out=8'hFF and frame_done=0.
REQ-024 SHALL, when reset is asserted mid-slot, abandon the current slot; after release, scanning SHALL restart at digit 0 with a full slot that begins with dead time.

Configuration
REQ-025 SHALL, when macro SSEG_LZ_BLANK_EN is defined, blank every digit above the highest digit whose shadow hex is non-zero; digit 0 SHALL never be blanked by this rule, and blank_in still ORs in.
REQ-026 SHALL, when SSEG_LZ_BLANK_EN is undefined, display every digit as given by blank_in, with no added logic.

Structure
REQ-027 SHALL place the glyph constants (SEG_0..SEG_F, SEG_OFF=8'hFF) and the dp bit position in shared package sseg_pkg.
REQ-028 SHALL implement the hex-to-glyph decode as sub-module sseg_glyph_rom (4-bit in, 7-bit active-high out, purely combinational), instantiated once on the selected digit.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-029 SHALL cover reset then enable=1 with no load: all anodes high, cathode 8'hFF throughout (everything blanked), frame_done pulses every 16 cycles.
REQ-030 SHALL cover load hex_in=16'h12AF, dp_in=4'b0100, blank_in=0: slot 0 gives anode 4'b1110 and cathode ~8'h71; slot 2 gives anode 4'b1011 and cathode ~8'hDB; each slot begins with one all-off cycle.
REQ-031 SHALL cover enable dropped mid-slot on digit 1: outputs go to all-off next cycle, digit_idx holds 1, and on re-enable the count resumes from the held cnt.
REQ-032 SHALL cover load coinciding with the digit advance: the new value appears only in the slot after the advance, with no torn digit.
REQ-033 SHALL cover, with SSEG_LZ_BLANK_EN defined, hex_in=16'h0050: digits 3 and 2 dark, digits 1 and 0 show 5 and 0; hex_in=0 shows only digit 0 as "0".
REQ-034 SHALL cover reset_n pulsed low during slot 3: outputs go to all-off asynchronously, and after release digit_idx=0 with the first frame_done 16 cycles later.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; pins are active-low.
package sseg_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int DP_BIT = 7;

endpackage

// File: rtl/sseg_glyph_rom.sv
// Hex nibble to active-high seven-segment glyph, purely combinational.
// Bit order of seg_o is {g,f,e,d,c,b,a}.
module sseg_glyph_rom
    import sseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_0;
        unique case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow register and dead time.
// Define SSEG_LZ_BLANK_EN to blank leading zero digits.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [7:0]              cathode_out,
    output logic [NUM_DIGITS-1:0]   anode_out,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d, sel_idx;
    logic [4*NUM_DIGITS-1:0] sh_hex_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_blank_q, blank_eff;
    logic [3:0]              cur_hex_q, cur_hex_d;
    logic                    cur_dp_q, cur_dp_d;
    logic                    cur_blank_q, cur_blank_d;
    logic [7:0]              cath_q, cath_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;
    logic                    wrap, adv, dark;
    logic [6:0]              glyph;

`ifdef SSEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;
    logic                  seen;

    always_comb begin
        lz   = '0;
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            seen  = seen | (sh_hex_q[4*k +: 4] != 4'h0);
            lz[k] = ~seen;
        end
    end

    assign blank_eff = sh_blank_q | lz;
`else
    assign blank_eff = sh_blank_q;
`endif

    sseg_glyph_rom u_rom (
        .hex_i (cur_hex_q),
        .seg_o (glyph)
    );

    always_comb begin
        wrap  = (cnt_q == CNT_LAST);
        adv   = enable && wrap;
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        if (adv) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Digit data is snapshotted once per slot so a load never tears it.
        sel_idx     = adv ? idx_d : idx_q;
        cur_hex_d   = cur_hex_q;
        cur_dp_d    = cur_dp_q;
        cur_blank_d = cur_blank_q;
        if (adv || !enable) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (int'(sel_idx) == k) begin
                    cur_hex_d   = sh_hex_q[4*k +: 4];
                    cur_dp_d    = sh_dp_q[k];
                    cur_blank_d = blank_eff[k];
                end
            end
        end

        dark   = !enable || (cnt_q == '0) || cur_blank_q;
        an_d   = '1;
        cath_d = SEG_OFF;
        if (!dark) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_d[k] = (int'(idx_q) != k);
            end
            cath_d = ~{cur_dp_q, glyph};
        end

        frame_d = adv && (idx_q == IDX_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_hex_q    <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            cur_hex_q   <= '0;
            cur_dp_q    <= 1'b0;
            cur_blank_q <= 1'b1;
            cath_q      <= SEG_OFF;
            an_q        <= '1;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            cur_hex_q   <= cur_hex_d;
            cur_dp_q    <= cur_dp_d;
            cur_blank_q <= cur_blank_d;
            cath_q      <= cath_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
            if (load) begin
                sh_hex_q   <= hex_in;
                sh_dp_q    <= dp_in;
                sh_blank_q <= blank_in;
            end
        end
    end

    assign cathode_out = cath_q;
    assign anode_out   = an_q;
    assign digit_idx   = idx_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
// Leading-zero expectations follow SSEG_LZ_BLANK_EN when defined.
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        load;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [7:0]  cathode_out;
    logic [3:0]  anode_out;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [3:0] an;
        logic [7:0] cath;
        logic [1:0] idx;
        logic       fd;
    } vec_t;

    vec_t       tbl [20];
    logic [7:0] seen [4];
    logic [7:0] lz_off;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .hex_in      (hex_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .cathode_out (cathode_out),
        .anode_out   (anode_out),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an, input logic [7:0] cath,
                           input logic [1:0] idx, input logic fd);
        chk({tag, " anode"}, 32'(anode_out), 32'(an));
        chk({tag, " cathode"}, 32'(cathode_out), 32'(cath));
        chk({tag, " digit_idx"}, 32'(digit_idx), 32'(idx));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(fd));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic capture();
        for (int d = 0; d < 4; d++) seen[d] = 8'hFF;
        for (int c = 0; c < 16; c++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                if (anode_out == ~(4'b0001 << d)) seen[d] = cathode_out;
            end
        end
    endtask

    initial begin
        bit found;
        int n;

        tbl[0]  = '{1'b1, 4'hF, 8'hFF, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'hE, 8'h8E, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'hE, 8'h8E, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'hE, 8'h8E, 2'd1, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 8'hFF, 2'd1, 1'b0};
        tbl[5]  = '{1'b1, 4'hD, 8'h88, 2'd1, 1'b0};
        tbl[6]  = '{1'b1, 4'hD, 8'h88, 2'd1, 1'b0};
        tbl[7]  = '{1'b1, 4'hD, 8'h88, 2'd2, 1'b0};
        tbl[8]  = '{1'b1, 4'hF, 8'hFF, 2'd2, 1'b0};
        tbl[9]  = '{1'b1, 4'hB, 8'h24, 2'd2, 1'b0};
        tbl[10] = '{1'b1, 4'hB, 8'h24, 2'd2, 1'b0};
        tbl[11] = '{1'b1, 4'hB, 8'h24, 2'd3, 1'b0};
        tbl[12] = '{1'b1, 4'hF, 8'hFF, 2'd3, 1'b0};
        tbl[13] = '{1'b1, 4'h7, 8'hF9, 2'd3, 1'b0};
        tbl[14] = '{1'b1, 4'h7, 8'hF9, 2'd3, 1'b0};
        tbl[15] = '{1'b1, 4'h7, 8'hF9, 2'd0, 1'b1};
        tbl[16] = '{1'b1, 4'hF, 8'hFF, 2'd0, 1'b0};
        tbl[17] = '{1'b1, 4'hE, 8'h8E, 2'd0, 1'b0};
        tbl[18] = '{1'b1, 4'hE, 8'h8E, 2'd0, 1'b0};
        tbl[19] = '{1'b1, 4'hE, 8'h8E, 2'd1, 1'b0};

        reset_n  = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        hex_in   = '0;
        dp_in    = '0;
        blank_in = '0;
        tick();
        tick();
        chk_out("reset", 4'hF, 8'hFF, 2'd0, 1'b0);

        // Free run with nothing loaded: dark, frame pulse every 16 cycles.
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("noload anode", 32'(anode_out), 32'hF);
            chk("noload cathode", 32'(cathode_out), 32'hFF);
            chk("noload frame", 32'(frame_done), 32'((i % 16) == 0));
        end

        // Reset, load 12AF while frozen, then scan one frame from the table.
        enable  = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n  = 1'b1;
        hex_in   = 16'h12AF;
        dp_in    = 4'b0100;
        blank_in = 4'b0000;
        load     = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk_out("frozen", 4'hF, 8'hFF, 2'd0, 1'b0);
        for (int r = 0; r < 20; r++) begin
            enable = tbl[r].en;
            tick();
            chk_out($sformatf("tbl%0d", r), tbl[r].an, tbl[r].cath, tbl[r].idx, tbl[r].fd);
        end

        // Drop enable mid-slot on digit 1 and resume from the held count.
        tick();
        chk_out("d1 dead", 4'hF, 8'hFF, 2'd1, 1'b0);
        tick();
        chk_out("d1 on", 4'hD, 8'h88, 2'd1, 1'b0);
        enable = 1'b0;
        tick();
        chk_out("freeze a", 4'hF, 8'hFF, 2'd1, 1'b0);
        tick();
        chk_out("freeze b", 4'hF, 8'hFF, 2'd1, 1'b0);
        enable = 1'b1;
        tick();
        chk_out("resume a", 4'hD, 8'h88, 2'd1, 1'b0);
        tick();
        chk_out("resume b", 4'hD, 8'h88, 2'd2, 1'b0);
        tick();
        chk_out("resume dead", 4'hF, 8'hFF, 2'd2, 1'b0);

        // Load coinciding with the advance into digit 3.
        tick();
        tick();
        hex_in = 16'h3456;
        dp_in  = 4'b0000;
        load   = 1'b1;
        tick();
        load = 1'b0;
        chk_out("adv load", 4'hB, 8'h24, 2'd3, 1'b0);
        tick();
        chk_out("adv dead", 4'hF, 8'hFF, 2'd3, 1'b0);
        tick();
        chk_out("old d3 a", 4'h7, 8'hF9, 2'd3, 1'b0);
        tick();
        chk_out("old d3 b", 4'h7, 8'hF9, 2'd3, 1'b0);
        tick();
        chk_out("old d3 c", 4'h7, 8'hF9, 2'd0, 1'b1);
        tick();
        chk_out("new d0 dead", 4'hF, 8'hFF, 2'd0, 1'b0);
        tick();
        chk_out("new d0", 4'hE, 8'h82, 2'd0, 1'b0);

        // Asynchronous reset during slot 3.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (digit_idx == 2'd3) found = 1'b1;
        end
        chk("reach slot3", 32'(found), 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk_out("async rst", 4'hF, 8'hFF, 2'd0, 1'b0);
        tick();
        reset_n = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (frame_done) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("rst frame latency", 32'(n), 32'd16);

        // Leading-zero handling on 0050 and 0000.
`ifdef SSEG_LZ_BLANK_EN
        lz_off = 8'hFF;
`else
        lz_off = 8'hC0;
`endif
        hex_in   = 16'h0050;
        dp_in    = 4'b0000;
        blank_in = 4'b0000;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        capture();
        chk("lz50 d0", 32'(seen[0]), 32'hC0);
        chk("lz50 d1", 32'(seen[1]), 32'h92);
        chk("lz50 d2", 32'(seen[2]), 32'(lz_off));
        chk("lz50 d3", 32'(seen[3]), 32'(lz_off));

        hex_in = 16'h0000;
        load   = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        capture();
        chk("lz0 d0", 32'(seen[0]), 32'hC0);
        chk("lz0 d1", 32'(seen[1]), 32'(lz_off));
        chk("lz0 d2", 32'(seen[2]), 32'(lz_off));
        chk("lz0 d3", 32'(seen[3]), 32'(lz_off));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
